// File: rtl/vis_stream_packer.sv
`default_nettype none
// ============================================================================
//  Module   : vis_stream_packer
//  Purpose  : Packs correlator visibility words (real/imag pairs) into framed
//             byte packets on an 8-bit AXI4-Stream. Each packet is a 4-byte
//             header (MAGIC high, MAGIC low, seq low, seq high) followed by
//             the little-endian real then imaginary bytes of every word.
//             A packet closes on s_last or after MAX_WORDS words; in the
//             second case trunc_o pulses. The remainder of that frame then
//             starts a new packet.
//  Ports    : bus_clock / bus_reset      clock, async active-high reset
//             s_valid/s_ready/s_last     correlator word handshake
//             s_revis/s_imvis            real / imaginary components
//             m_tvalid/m_tready          AXI-S byte handshake
//             m_tlast/m_tdata            AXI-S last flag and byte
//             seq_o                      sequence number of next packet
//             trunc_o                    pulse on the beat closing a
//                                        truncated packet
//  Revision : 1.0 - initial release
// ============================================================================
module vis_stream_packer #(
   parameter int          ACCUM     = 32,
   parameter int          MAX_WORDS = 256,
   parameter logic [15:0] MAGIC     = 16'hA55A
) (
   input  logic             bus_clock,
   input  logic             bus_reset,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic             s_last,
   input  logic [ACCUM-1:0] s_revis,
   input  logic [ACCUM-1:0] s_imvis,
   output logic             m_tvalid,
   input  logic             m_tready,
   output logic             m_tlast,
   output logic [7:0]       m_tdata,
   output logic [15:0]      seq_o,
   output logic             trunc_o
);

   localparam int NB = 2 * ACCUM / 8;            // bytes per word
   localparam int BW = $clog2(NB);
   localparam int CW = $clog2(MAX_WORDS + 1);
   // The first byte of a word goes straight to m_tdata, so the shift
   // register only needs to hold the remaining NB-1 bytes.
   localparam int SW = 2 * ACCUM - 8;

   localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);
   localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_WORDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HEAD = 2'd1,
      LOAD = 2'd2,
      SEND = 2'd3
   } state_t;

   state_t          state;
   logic [1:0]      hdr_idx;
   logic [SW-1:0]   shreg;
   logic            last_word;
   logic [BW-1:0]   byte_idx;
   logic [CW-1:0]   word_cnt;
   logic [15:0]     seq;

   logic            accept;
   logic            closing;
   logic            final_beat;

   function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [15:0] sq);
      logic [7:0] b;
      case (idx)
         2'd0:    b = MAGIC[15:8];
         2'd1:    b = MAGIC[7:0];
         2'd2:    b = sq[7:0];
         default: b = sq[15:8];
      endcase
      return b;
   endfunction

   assign accept     = m_tvalid & m_tready;
   // word_cnt already counts the word being sent, so this is the packet
   // closing condition for the current word.
   assign closing    = last_word | (word_cnt == MAX_CNT);
   assign final_beat = (state == SEND) & accept & (byte_idx == LAST_BYTE);

   assign s_ready = (state == LOAD);
   assign seq_o   = seq;
   assign trunc_o = final_beat & ~last_word & (word_cnt == MAX_CNT);

   always_ff @(posedge bus_clock or posedge bus_reset) begin
      if (bus_reset) begin
         state     <= IDLE;
         hdr_idx   <= 2'd0;
         shreg     <= '0;
         last_word <= 1'b0;
         byte_idx  <= '0;
         word_cnt  <= '0;
         seq       <= 16'd0;
         m_tvalid  <= 1'b0;
         m_tlast   <= 1'b0;
         m_tdata   <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               // The pending word is left on the bus; it is taken in LOAD
               // once the header has gone out.
               if (s_valid) begin
                  state    <= HEAD;
                  hdr_idx  <= 2'd0;
                  m_tvalid <= 1'b1;
                  m_tlast  <= 1'b0;
                  m_tdata  <= hdr_byte(2'd0, seq);
               end
            end

            HEAD: begin
               if (accept) begin
                  if (hdr_idx == 2'd3) begin
                     state    <= LOAD;
                     m_tvalid <= 1'b0;
                     m_tdata  <= 8'd0;
                  end else begin
                     hdr_idx <= hdr_idx + 2'd1;
                     m_tdata <= hdr_byte(hdr_idx + 2'd1, seq);
                  end
               end
            end

            LOAD: begin
               if (s_valid) begin
                  state     <= SEND;
                  shreg     <= {s_imvis, s_revis[ACCUM-1:8]};
                  last_word <= s_last;
                  word_cnt  <= word_cnt + CW'(1);
                  byte_idx  <= '0;
                  m_tvalid  <= 1'b1;
                  m_tlast   <= 1'b0;
                  m_tdata   <= s_revis[7:0];
               end
            end

            SEND: begin
               if (accept) begin
                  if (byte_idx == LAST_BYTE) begin
                     m_tvalid <= 1'b0;
                     m_tlast  <= 1'b0;
                     m_tdata  <= 8'd0;
                     if (closing) begin
                        state    <= IDLE;
                        seq      <= seq + 16'd1;
                        word_cnt <= '0;
                     end else begin
                        state <= LOAD;
                     end
                  end else begin
                     byte_idx <= byte_idx + BW'(1);
                     m_tdata  <= shreg[7:0];
                     shreg    <= shreg >> 8;
                     m_tlast  <= ((byte_idx + BW'(1)) == LAST_BYTE) & closing;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vis_stream_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vis_stream_packer
//  Purpose  : Self-checking bench for vis_stream_packer (ACCUM=32,
//             MAX_WORDS=4). Frame records are applied from a table; reset,
//             sequence wrap and back-pressure are hand-written sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vis_stream_packer;

   localparam int ACCUM     = 32;
   localparam int MAX_WORDS = 4;
   localparam int NB        = 2 * ACCUM / 8;

   logic              bus_clock = 1'b0;
   logic              bus_reset;
   logic              s_valid;
   logic              s_ready;
   logic              s_last;
   logic [ACCUM-1:0]  s_revis;
   logic [ACCUM-1:0]  s_imvis;
   logic              m_tvalid;
   logic              m_tready;
   logic              m_tlast;
   logic [7:0]        m_tdata;
   logic [15:0]       seq_o;
   logic              trunc_o;

   int checks = 0;
   int fails  = 0;

   always #5 bus_clock = ~bus_clock;

   vis_stream_packer #(
      .ACCUM     (ACCUM),
      .MAX_WORDS (MAX_WORDS),
      .MAGIC     (16'hA55A)
   ) dut (
      .bus_clock (bus_clock),
      .bus_reset (bus_reset),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_last    (s_last),
      .s_revis   (s_revis),
      .s_imvis   (s_imvis),
      .m_tvalid  (m_tvalid),
      .m_tready  (m_tready),
      .m_tlast   (m_tlast),
      .m_tdata   (m_tdata),
      .seq_o     (seq_o),
      .trunc_o   (trunc_o)
   );

   typedef struct {
      int          nwords;
      logic [31:0] re0;
      logic [31:0] im0;
      logic [31:0] step;     // word i carries re0+i*step / im0+i*step
      bit          rnd;      // random m_tready
      int          exp_len;
      int          exp_trunc;
      logic [15:0] seq0;
      logic [15:0] exp_seq;
   } frame_vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- cycle counter and m_tready driver ----------------
   int cyc = 0;
   bit   ready_rnd   = 1'b0;
   logic ready_fixed = 1'b1;

   initial forever begin
      @(posedge bus_clock);
      cyc++;
      #1;
      m_tready = ready_rnd ? 1'($urandom_range(0, 1)) : ready_fixed;
   end

   // ---------------- monitor ----------------
   logic [7:0] cap_d[$];
   bit         cap_l[$];
   int         cap_cyc[$];
   int         cap_tr[$];
   int         pkt_pos = 0;
   bit         prev_stall = 1'b0;
   logic [7:0] prev_d;
   logic       prev_l;

   initial forever begin
      @(negedge bus_clock);
      if (bus_reset) begin
         prev_stall = 1'b0;
         pkt_pos    = 0;
      end else begin
         if (prev_stall)
            check("axis_hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, prev_l, prev_d});
         if (s_ready)
            check("s_ready_after_header", 64'(pkt_pos >= 4), 64'd1);
         if (trunc_o)
            check("trunc_on_last_beat", 64'(m_tvalid && m_tready && m_tlast), 64'd1);
         if (m_tvalid && m_tready) begin
            if (pkt_pos < 4)
               check("no_tlast_in_header", 64'(m_tlast), 64'd0);
            cap_d.push_back(m_tdata);
            cap_l.push_back(m_tlast);
            cap_cyc.push_back(cyc);
            if (trunc_o)
               cap_tr.push_back(cap_d.size() - 1);
            pkt_pos = m_tlast ? 0 : pkt_pos + 1;
         end
         prev_stall = m_tvalid && !m_tready;
         prev_d     = m_tdata;
         prev_l     = m_tlast;
      end
   end

   // ---------------- reference model ----------------
   logic [7:0] exp_d[$];
   bit         exp_l[$];
   int         exp_tr[$];

   function automatic void build_expected(input frame_vec_t v);
      logic [15:0] sq;
      logic [31:0] re;
      logic [31:0] im;
      int w;
      int cnt;
      bit closing;
      exp_d.delete(); exp_l.delete(); exp_tr.delete();
      sq = v.seq0;
      w  = 0;
      while (w < v.nwords) begin
         exp_d.push_back(8'hA5);    exp_l.push_back(1'b0);
         exp_d.push_back(8'h5A);    exp_l.push_back(1'b0);
         exp_d.push_back(sq[7:0]);  exp_l.push_back(1'b0);
         exp_d.push_back(sq[15:8]); exp_l.push_back(1'b0);
         cnt = 0;
         closing = 1'b0;
         while (!closing) begin
            re = v.re0 + 32'(w) * v.step;
            im = v.im0 + 32'(w) * v.step;
            cnt++;
            closing = (w == v.nwords - 1) || (cnt == MAX_WORDS);
            for (int b = 0; b < 4; b++) begin
               exp_d.push_back(re[8*b +: 8]); exp_l.push_back(1'b0);
            end
            for (int b = 0; b < 4; b++) begin
               exp_d.push_back(im[8*b +: 8]);
               exp_l.push_back(closing && (b == 3));
            end
            if (closing && (w != v.nwords - 1))
               exp_tr.push_back(exp_d.size() - 1);
            w++;
         end
         sq = sq + 16'd1;
      end
   endfunction

   // ---------------- helpers ----------------
   task automatic clear_capture();
      cap_d.delete(); cap_l.delete(); cap_cyc.delete(); cap_tr.delete();
   endtask

   task automatic send_words(input int n, input logic [31:0] re0, input logic [31:0] im0,
                             input logic [31:0] step);
      for (int i = 0; i < n; i++) begin
         int t;
         s_valid = 1'b1;
         s_last  = (i == n - 1);
         s_revis = re0 + 32'(i) * step;
         s_imvis = im0 + 32'(i) * step;
         t = 0;
         while (t < 1000) begin
            @(negedge bus_clock);
            if (s_ready && !bus_reset) break;
            t++;
         end
         if (t >= 1000) begin
            check("word_accept_timeout", 64'(i), 64'(n));
            s_valid = 1'b0;
            s_last  = 1'b0;
            return;
         end
         @(posedge bus_clock);
         #1;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic wait_bytes(input int n);
      int t = 0;
      while (cap_d.size() < n && t < 3000) begin
         @(negedge bus_clock);
         t++;
      end
      if (cap_d.size() < n)
         check("drain_timeout", 64'(cap_d.size()), 64'(n));
   endtask

   task automatic compare_packets(input frame_vec_t v, input string tag);
      check({tag, "_byte_count"}, 64'(cap_d.size()), 64'(v.exp_len));
      for (int i = 0; i < exp_d.size(); i++)
         if (i < cap_d.size())
            check($sformatf("%s_byte%0d", tag, i), {cap_l[i], cap_d[i]}, {exp_l[i], exp_d[i]});
      check({tag, "_trunc_count"}, 64'(cap_tr.size()), 64'(v.exp_trunc));
      for (int i = 0; i < cap_tr.size(); i++)
         if (i < exp_tr.size())
            check({tag, "_trunc_pos"}, 64'(cap_tr[i]), 64'(exp_tr[i]));
      check({tag, "_seq_after"}, 64'(seq_o), 64'(v.exp_seq));
   endtask

   task automatic run_frame(input frame_vec_t v, input string tag);
      clear_capture();
      build_expected(v);
      ready_rnd = v.rnd;
      send_words(v.nwords, v.re0, v.im0, v.step);
      wait_bytes(v.exp_len);
      repeat (3) @(posedge bus_clock);
      #1;
      ready_rnd = 1'b0;
      compare_packets(v, tag);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_m_tvalid"}, 64'(m_tvalid), 64'd0);
      check({tag, "_m_tlast"},  64'(m_tlast),  64'd0);
      check({tag, "_m_tdata"},  64'(m_tdata),  64'd0);
      check({tag, "_seq_o"},    64'(seq_o),    64'd0);
      check({tag, "_s_ready"},  64'(s_ready),  64'd0);
      check({tag, "_trunc_o"},  64'(trunc_o),  64'd0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   frame_vec_t tbl[6];

   initial begin
      frame_vec_t v;

      //                 n  re0           im0           step          rnd len trunc seq0    exp_seq
      tbl[0] = '{3, 32'h04030201, 32'h08070605, 32'h00000000, 1'b0, 28, 0, 16'd0, 16'd1};
      tbl[1] = '{3, 32'h04030201, 32'h08070605, 32'h00000000, 1'b1, 28, 0, 16'd1, 16'd2};
      tbl[2] = '{1, 32'hDEADBEEF, 32'h80000001, 32'h00000000, 1'b0, 12, 0, 16'd2, 16'd3};
      tbl[3] = '{4, 32'h10203040, 32'h50607080, 32'h01010101, 1'b0, 36, 0, 16'd3, 16'd4};
      tbl[4] = '{6, 32'hA0A1A2A3, 32'hB0B1B2B3, 32'h00000100, 1'b1, 56, 1, 16'd4, 16'd6};
      tbl[5] = '{8, 32'h00000001, 32'hFFFFFFF0, 32'h00010001, 1'b0, 72, 1, 16'd6, 16'd8};

      bus_reset = 1'b1;
      s_valid   = 1'b0;
      s_last    = 1'b0;
      s_revis   = '0;
      s_imvis   = '0;
      m_tready  = 1'b1;

      repeat (2) @(negedge bus_clock);
      check_zero("reset");
      @(posedge bus_clock);
      #1;
      bus_reset = 1'b0;
      repeat (2) @(posedge bus_clock);
      #1;

      for (int i = 0; i < 6; i++)
         run_frame(tbl[i], $sformatf("vec%0d", i));

      // Sequence number wrap.
      @(posedge bus_clock);
      #1;
      force dut.seq = 16'hFFFF;
      #1;
      release dut.seq;
      @(negedge bus_clock);
      check("seq_preload", 64'(seq_o), 64'hFFFF);
      #1;
      v = '{1, 32'h01234567, 32'h89ABCDEF, 32'h0, 1'b0, 12, 0, 16'hFFFF, 16'h0000};
      run_frame(v, "wrap_ffff");
      v = '{1, 32'h76543210, 32'hFEDCBA98, 32'h0, 1'b0, 12, 0, 16'h0000, 16'h0001};
      run_frame(v, "wrap_0000");

      // Reset during byte 5 of word 2; the held-off third word must survive.
      clear_capture();
      v = '{1, 32'h11223344 + 32'd2 * 32'h01010101, 32'h55667788 + 32'd2 * 32'h01010101,
            32'h0, 1'b0, 12, 0, 16'd0, 16'd1};
      fork
         send_words(3, 32'h11223344, 32'h55667788, 32'h01010101);
         begin
            wait_bytes(16);
            @(posedge bus_clock);
            #1;
            bus_reset = 1'b1;
            #2;
            check_zero("midreset");
            repeat (3) @(posedge bus_clock);
            #1;
            clear_capture();
            bus_reset = 1'b0;
         end
      join
      build_expected(v);
      wait_bytes(12);
      repeat (3) @(posedge bus_clock);
      #1;
      compare_packets(v, "after_reset");

      // Back-pressure on header byte 0, then throughput under constant ready.
      ready_fixed = 1'b0;
      @(posedge bus_clock);
      #2;
      clear_capture();
      v = '{3, 32'hC0C1C2C3, 32'hD0D1D2D3, 32'h00000011, 1'b0, 28, 0, 16'd1, 16'd2};
      build_expected(v);
      fork
         send_words(3, v.re0, v.im0, v.step);
         begin
            @(posedge bus_clock);
            repeat (6) begin
               @(negedge bus_clock);
               check("stall_hold_hdr0", {s_ready, m_tvalid, m_tlast, m_tdata},
                     {1'b0, 1'b1, 1'b0, 8'hA5});
            end
            ready_fixed = 1'b1;
         end
      join
      wait_bytes(28);
      repeat (3) @(posedge bus_clock);
      #1;
      compare_packets(v, "stall");
      if (cap_cyc.size() >= 28) begin
         check("hdr_beats_back_to_back", 64'(cap_cyc[3] - cap_cyc[0]), 64'd3);
         check("load_bubble_after_hdr",  64'(cap_cyc[4] - cap_cyc[3]), 64'd2);
         check("word_period_1",          64'(cap_cyc[12] - cap_cyc[4]), 64'(NB + 1));
         check("word_period_2",          64'(cap_cyc[20] - cap_cyc[12]), 64'(NB + 1));
         check("word_bytes_back_to_back", 64'(cap_cyc[27] - cap_cyc[20]), 64'(NB - 1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
`default_nettype wire
